// File: rtl/demux1a4_pkg.sv
// Shared definitions for the 1:4 byte un-striping stage: lane count, index
// width, full-group mask, fill-state encoding and the partial-group mask helper.
package demux1a4_pkg;

  localparam int DEMUX_LANES = 4;
  localparam int LANE_IDX_W  = 2;

  localparam logic [DEMUX_LANES-1:0] MASK_FULL = 4'b1111;
  localparam logic [LANE_IDX_W-1:0]  LANE_LAST = 2'(DEMUX_LANES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_e;

  // Lanes below idx carry data: idx=2 -> 4'b0011.
  function automatic logic [DEMUX_LANES-1:0] mask_below(input logic [LANE_IDX_W-1:0] idx);
    return 4'((5'b00001 << idx) - 5'd1);
  endfunction

endpackage

// File: rtl/lane_reg4.sv
// Four-lane registered output stage: loads all lanes together on load,
// synchronous active-low clear, holds otherwise.
module lane_reg4
  import demux1a4_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clkf,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] d0,
  input  logic [DATA_W-1:0] d1,
  input  logic [DATA_W-1:0] d2,
  input  logic [DATA_W-1:0] d3,
  output logic [DATA_W-1:0] q0,
  output logic [DATA_W-1:0] q1,
  output logic [DATA_W-1:0] q2,
  output logic [DATA_W-1:0] q3
);

  logic [DATA_W-1:0] lane_q [DEMUX_LANES];
  logic [DATA_W-1:0] lane_d [DEMUX_LANES];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    lane_d = lane_q;
    if (load) begin
      lane_d[0] = d0;
      lane_d[1] = d1;
      lane_d[2] = d2;
      lane_d[3] = d3;
    end
  end

  // NOTE: reset is sampled on the clock edge only (synchronous), and state uses <= so
  // every flop sees pre-edge values regardless of process ordering.
  always_ff @(posedge clkf) begin
    if (!reset) lane_q <= '{default: '0};
    else        lane_q <= lane_d;
  end

  assign q0 = lane_q[0];
  assign q1 = lane_q[1];
  assign q2 = lane_q[2];
  assign q3 = lane_q[3];

endmodule

// File: rtl/demux1a4.sv
// 1:4 byte un-striping stage: round-robin fill of three staging bytes plus the
// live byte into a registered 4-lane group. Optional idle flush: DEMUX_FLUSH_EN.
module demux1a4
  import demux1a4_pkg::*;
#(
  parameter int DATA_W        = 8,
  parameter int FLUSH_TIMEOUT = 4
) (
  input  logic                   clkf,
  input  logic                   reset,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   in_valid,
  output logic [DATA_W-1:0]      out0,
  output logic [DATA_W-1:0]      out1,
  output logic [DATA_W-1:0]      out2,
  output logic [DATA_W-1:0]      out3,
  output logic                   out_valid,
  output logic [DEMUX_LANES-1:0] out_mask,
  output logic [LANE_IDX_W-1:0]  lane_idx
);

  if (FLUSH_TIMEOUT < 1 || FLUSH_TIMEOUT > 15) begin : g_bad_timeout
    $error("demux1a4: FLUSH_TIMEOUT must be in 1..15");
  end

  logic [LANE_IDX_W-1:0]  lane_idx_q, lane_idx_d;
  logic [DATA_W-1:0]      stg_q [DEMUX_LANES-1];
  logic [DATA_W-1:0]      stg_d [DEMUX_LANES-1];
  logic                   out_valid_q, out_valid_d;
  logic [DEMUX_LANES-1:0] out_mask_q, out_mask_d;

  logic full_grp, flush, emit;
  logic [DATA_W-1:0] lane0_in, lane1_in, lane2_in, lane3_in;

`ifdef DEMUX_FLUSH_EN
  localparam logic [3:0] TIMEOUT_C = 4'(FLUSH_TIMEOUT);

  state_e     state;
  logic [3:0] idle_cnt_q, idle_cnt_d;

  assign state = (lane_idx_q == '0) ? IDLE : FILL;

  // A valid byte always resets the count, so a byte on the would-be flush edge is kept.
  always_comb begin
    idle_cnt_d = idle_cnt_q;
    flush      = 1'b0;
    if (in_valid || state == IDLE) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q + 4'd1 == TIMEOUT_C) begin
      flush      = 1'b1;
      idle_cnt_d = '0;
    end else begin
      idle_cnt_d = idle_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clkf) begin
    if (!reset) idle_cnt_q <= '0;
    else        idle_cnt_q <= idle_cnt_d;
  end
`else
  assign flush = 1'b0;
`endif

  assign full_grp = in_valid && (lane_idx_q == LANE_LAST);
  assign emit     = full_grp || flush;

  always_comb begin
    lane_idx_d  = lane_idx_q;
    stg_d       = stg_q;
    out_valid_d = 1'b0;
    out_mask_d  = '0;
    lane0_in    = stg_q[0];
    lane1_in    = stg_q[1];
    lane2_in    = stg_q[2];
    lane3_in    = in_data;

    if (emit) begin
      out_valid_d = 1'b1;
      out_mask_d  = full_grp ? MASK_FULL : mask_below(lane_idx_q);
      if (!full_grp) begin
        lane0_in = out_mask_d[0] ? stg_q[0] : '0;
        lane1_in = out_mask_d[1] ? stg_q[1] : '0;
        lane2_in = out_mask_d[2] ? stg_q[2] : '0;
        lane3_in = '0;
      end
      lane_idx_d = '0;
      stg_d      = '{default: '0};
    end else if (in_valid) begin
      case (lane_idx_q)
        2'd0:    stg_d[0] = in_data;
        2'd1:    stg_d[1] = in_data;
        2'd2:    stg_d[2] = in_data;
        default: ;
      endcase
      lane_idx_d = lane_idx_q + 2'd1;
    end
  end

  always_ff @(posedge clkf) begin
    if (!reset) begin
      lane_idx_q  <= '0;
      stg_q       <= '{default: '0};
      out_valid_q <= 1'b0;
      out_mask_q  <= '0;
    end else begin
      lane_idx_q  <= lane_idx_d;
      stg_q       <= stg_d;
      out_valid_q <= out_valid_d;
      out_mask_q  <= out_mask_d;
    end
  end

  lane_reg4 #(.DATA_W(DATA_W)) u_lanes (
    .clkf  (clkf),
    .reset (reset),
    .load  (emit),
    .d0    (lane0_in),
    .d1    (lane1_in),
    .d2    (lane2_in),
    .d3    (lane3_in),
    .q0    (out0),
    .q1    (out1),
    .q2    (out2),
    .q3    (out3)
  );

  assign out_valid = out_valid_q;
  assign out_mask  = out_mask_q;
  assign lane_idx  = lane_idx_q;

endmodule

// File: tb/tb_demux1a4.sv
// Directed bench for demux1a4: every emitted group is logged with its cycle and
// compared against hand-computed groups and latencies.
module tb_demux1a4;

  localparam int TB_TIMEOUT = 4;

  logic       clkf;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic [7:0] out0, out1, out2, out3;
  logic       out_valid;
  logic [3:0] out_mask;
  logic [1:0] lane_idx;

  demux1a4 #(.DATA_W(8), .FLUSH_TIMEOUT(TB_TIMEOUT)) dut (
    .clkf      (clkf),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .out0      (out0),
    .out1      (out1),
    .out2      (out2),
    .out3      (out3),
    .out_valid (out_valid),
    .out_mask  (out_mask),
    .lane_idx  (lane_idx)
  );

  initial clkf = 1'b0;
  always #5 clkf = ~clkf;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  mask;
    int          cyc;
  } group_t;

  group_t groups[$];
  int     n_cmp = 0;
  int     n_err = 0;
  int     cyc = 0;
  int     last_edge = 0;
  int     first_edge = 0;
  bit     mon_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clkf) cyc <= cyc + 1;

  // Log each strobed cycle; a two-cycle strobe shows up as an extra group.
  always @(negedge clkf) begin
    if (mon_en) begin
      if (out_valid === 1'b1) groups.push_back('{data: {out0, out1, out2, out3}, mask: out_mask, cyc: cyc});
      if (out_valid !== 1'b1 && out_mask !== 4'b0000) check("mask_when_idle", 32'(out_mask), 32'h0);
    end
  end

  // Inputs change on the falling edge; the next rising edge samples them.
  task automatic drive(input logic v, input logic [7:0] d);
    @(negedge clkf);
    in_valid = v;
    in_data  = d;
    if (v) last_edge = cyc + 1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00);
  endtask

  task automatic check_group(input string tag, input int idx, input logic [31:0] data,
                             input logic [3:0] mask, input int exp_cyc);
    if (groups.size() > idx) begin
      check({tag, "_data"}, groups[idx].data, data);
      check({tag, "_mask"}, 32'(groups[idx].mask), 32'(mask));
      check({tag, "_cyc"}, 32'(groups[idx].cyc), 32'(exp_cyc));
    end else begin
      check({tag, "_missing"}, 32'(groups.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    logic [7:0] bytes [8];
    int         g0_edge;

    // Reset with junk input present: must be ignored.
    reset    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h5A;
    repeat (3) @(negedge clkf);
    mon_en = 1'b1;
    check("rst_out", {out0, out1, out2, out3}, 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_mask", 32'(out_mask), 32'h0);
    check("rst_lane_idx", 32'(lane_idx), 32'h0);
    reset    = 1'b1;
    in_valid = 1'b0;
    idle(10);
    check("idle_groups", 32'(groups.size()), 32'd0);
    check("idle_out", {out0, out1, out2, out3}, 32'h0);
    check("idle_lane_idx", 32'(lane_idx), 32'h0);

    // Back-to-back stream, two groups four cycles apart.
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    groups.delete();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, bytes[i]);
      if (i == 3) g0_edge = last_edge;
    end
    idle(3);
    check("b2b_count", 32'(groups.size()), 32'd2);
    check_group("b2b_g0", 0, 32'h11223344, 4'hF, g0_edge);
    check_group("b2b_g1", 1, 32'h55667788, 4'hF, g0_edge + 4);
    check("b2b_hold", {out0, out1, out2, out3}, 32'h55667788);

    // Gapped input.
    groups.delete();
    drive(1'b1, 8'hA0);
    idle(2);
    check("gap_lane_idx1", 32'(lane_idx), 32'd1);
    drive(1'b1, 8'hA1);
    drive(1'b1, 8'hA2);
    idle(1);
    check("gap_lane_idx3", 32'(lane_idx), 32'd3);
    check("gap_no_early", 32'(groups.size()), 32'd0);
    drive(1'b1, 8'hA3);
    idle(3);
    check("gap_count", 32'(groups.size()), 32'd1);
    check_group("gap_g0", 0, 32'hA0A1A2A3, 4'hF, last_edge);

    // Reset mid-group discards the partial group.
    groups.delete();
    drive(1'b1, 8'hC1);
    drive(1'b1, 8'hC2);
    @(negedge clkf);
    reset    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hCC;
    @(negedge clkf);
    reset    = 1'b1;
    in_valid = 1'b0;
    check("midrst_lane_idx", 32'(lane_idx), 32'd0);
    check("midrst_out", {out0, out1, out2, out3}, 32'h0);
    for (int i = 0; i < 4; i++) drive(1'b1, 8'hD0 + 8'(i));
    idle(3);
    check("midrst_count", 32'(groups.size()), 32'd1);
    check_group("midrst_g0", 0, 32'hD0D1D2D3, 4'hF, last_edge);

    // Partial group.
    groups.delete();
    drive(1'b1, 8'hE0);
    drive(1'b1, 8'hE1);
    first_edge = last_edge;
    idle(6);
`ifdef DEMUX_FLUSH_EN
    check("flush_count", 32'(groups.size()), 32'd1);
    check_group("flush_g0", 0, 32'hE0E10000, 4'b0011, first_edge + TB_TIMEOUT);
    check("flush_lane_idx", 32'(lane_idx), 32'd0);

    // A byte on the would-be flush edge cancels the flush.
    groups.delete();
    drive(1'b1, 8'hF0);
    idle(TB_TIMEOUT - 1);
    drive(1'b1, 8'hF1);
    drive(1'b1, 8'hF2);
    drive(1'b1, 8'hF3);
    idle(2);
    check("race_count", 32'(groups.size()), 32'd1);
    check_group("race_g0", 0, 32'hF0F1F2F3, 4'hF, last_edge);
`else
    check("nofl_count", 32'(groups.size()), 32'd0);
    check("nofl_lane_idx", 32'(lane_idx), 32'd2);
    drive(1'b1, 8'hE2);
    drive(1'b1, 8'hE3);
    idle(2);
    check("nofl_done_count", 32'(groups.size()), 32'd1);
    check_group("nofl_g0", 0, 32'hE0E1E2E3, 4'hF, last_edge);
    check("nofl_lane_idx0", 32'(lane_idx), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/demux1a4.md
# demux1a4

Byte un-striping stage for the physical-layer datapath: accepts a single 8-bit byte stream with a valid qualifier on `clkf` and distributes consecutive bytes round-robin onto four parallel lanes, presenting a complete 4-byte group with a one-cycle `out_valid` strobe. It is the receive-side inverse of the 4:1 lane multiplexer. Lanes feed the per-lane flop stages downstream.

## Interface
- `DATA_W`, 8, width of each byte/lane.
- `FLUSH_TIMEOUT`, 4, consecutive idle cycles before a partial group is flushed; range 1..15; used only with `DEMUX_FLUSH_EN`.

- `clkf`  input  1  clock; all state updates on the rising edge.
- `reset`  input  1  reset, synchronous, active-low.
- `in_data`  input  DATA_W  incoming byte.
- `in_valid`  input  1  `in_data` is valid this cycle.
- `out0`..`out3`  output  DATA_W each  lane bytes; `out0` carries the first byte of a group.
- `out_valid`  output  1  one-cycle strobe: the lanes hold a new group.
- `out_mask`  output  4  lanes carrying real data in the current group; bit n is `outn`.
- `lane_idx`  output  2  next lane to be filled; for status only.

## Operation
- Internal state: `lane_idx` counter (0..3) and staging registers `stg0`..`stg2`.
- States: `IDLE` when `lane_idx` = 0; `FILL` when `lane_idx` is 1..3.
- `in_valid`=1 and `lane_idx` < 3: the staging register for that lane takes `in_data`; `lane_idx` increments.
- `in_valid`=1 and `lane_idx` = 3:
  - `{out0,out1,out2,out3}` take `{stg0,stg1,stg2,in_data}`.
  - `out_valid` is 1 and `out_mask` is 4'b1111 for the next cycle.
  - `lane_idx` wraps to 0.
  - Staging registers clear to 0.
- `in_valid`=0: staging registers and `lane_idx` hold. No bytes are dropped.
- `out_valid` is 1 for exactly one cycle per emitted group and 0 otherwise.
- `out_mask` is 0 whenever `out_valid` is 0.
- `out0`..`out3` hold the last emitted group until the next emit.
- Back-to-back input with `in_valid` continuously 1 gives one group every 4 cycles. There is no back-pressure.
- Reset (`reset`=0 at an edge) takes priority over all other events, including mid-group.
  - Reset values: all of `out0`..`out3` = 0, `out_valid`=0, `out_mask`=0, `lane_idx`=0, `stg*`=0.
  - A partially filled group is discarded; nothing is emitted.
  - Input bytes presented during reset are ignored.

## Timing
- Latency: the group appears with `out_valid`=1 in the cycle after the edge that samples the 4th byte. That is 1 cycle from the last byte and 4 cycles from the first byte when input is back-to-back.
- All outputs are registered; there are no combinational paths from input to output.
- `lane_idx` updates on the same edge as the staging write.

## Configuration
- `DEMUX_FLUSH_EN` defined:
  - An idle counter counts consecutive `in_valid`=0 cycles while `lane_idx` != 0.
  - On the edge where the count reaches `FLUSH_TIMEOUT`, the partial group is emitted:
    - filled lanes take their staged bytes;
    - unfilled lanes are 0;
    - `out_mask` has bit n set for n < `lane_idx`;
    - `out_valid`=1 for one cycle.
  - After the flush, `lane_idx`=0 and the idle counter clears.
  - Any `in_valid`=1 cycle clears the idle counter.
  - A byte arriving on the flush edge is never lost: at that edge `in_valid`=1, so the timeout is not reached that cycle.
  - With `lane_idx` = 0 the counter stays at 0.
- `DEMUX_FLUSH_EN` not defined:
  - No idle counter and no flush.
  - A partial group waits indefinitely for completion.
  - `out_mask` is 4'b1111 whenever `out_valid`=1.
  - `FLUSH_TIMEOUT` is ignored.

## Structure
- Shared package: `DEMUX_LANES`=4, lane-index width 2, `MASK_FULL`=4'b1111, and the `IDLE`/`FILL` state encoding.
- One sub-module: `lane_reg4`, a 4-lane registered output stage with synchronous active-low clear and a load enable. It is instantiated once for `out0`..`out3`.
- The counter, staging registers, and flush logic live in `demux1a4`.

## Test plan
- Reset then idle: hold `reset`=0 for 3 cycles, release, keep `in_valid`=0 for 10 cycles -> every output stays 0 and `out_valid` is never 1.
- Back-to-back stream: `in_valid`=1 with bytes 0x11,0x22,0x33,0x44,0x55,0x66,0x77,0x88 ->
  - first group: `out0..3`=0x11,0x22,0x33,0x44 with `out_valid` one cycle after 0x44;
  - second group: 0x55..0x88 with `out_valid` one cycle after 0x88, exactly 4 cycles after the first;
  - `out_mask`=4'b1111 for both.
- Gapped input: bytes 0xA0, gap of 2 cycles, 0xA1, 0xA2, gap of 1 cycle, 0xA3 -> one group 0xA0,0xA1,0xA2,0xA3; `out_valid` one cycle after 0xA3; no earlier strobe.
- Reset mid-group: send 0xC1, 0xC2, assert reset for 1 cycle, then send 0xD0..0xD3 -> the only group emitted is 0xD0,0xD1,0xD2,0xD3; `lane_idx`=0 after reset.
- Partial group, build-dependent: send 0xE0, 0xE1, then idle for 6 cycles.
  - With `DEMUX_FLUSH_EN` and `FLUSH_TIMEOUT`=4: 4 idle cycles after 0xE1 -> `out0`=0xE0, `out1`=0xE1, `out2`=`out3`=0, `out_mask`=4'b0011, one `out_valid` strobe, `lane_idx`=0.
  - Without the macro: no strobe, `lane_idx`=2; sending 0xE2, 0xE3 then completes the group 0xE0..0xE3.
- Flush race (`DEMUX_FLUSH_EN`, `FLUSH_TIMEOUT`=2): send 0xF0, idle 1 cycle, 0xF1 on the cycle the timeout would otherwise be reached, then 0xF2, 0xF3 -> no partial flush; a full group 0xF0..0xF3 with mask 4'b1111.
